id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS pipeline, directly upstream of the ALU control decoder and ALU.
- Captures decoded control (ALUOp, Funct, Opcode, write/memory controls), register operands, immediate and register numbers at the ID→EX boundary.
- Contains the load-use hazard detector: on a hazard it stalls IF/ID and inserts a one-cycle bubble. It also handles the branch flush.
- Keeps a saturating count of inserted bubbles.

---
 rtl/id_ex_stage.sv | 107 ++++++++++
 tb/tb_id_ex_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the 5-stage MIPS pipeline.
// Also detects load-use hazards, inserts bubbles, handles branch flush and counts bubbles.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic [5:0]        id_opcode,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_uses_rt,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    output logic              ex_valid,
    output logic [1:0]        ex_alu_op,
    output logic [5:0]        ex_funct,
    output logic [5:0]        ex_opcode,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic              stall,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic haz;

    // A load in EX whose destination is read by the instruction in ID; $0 never conflicts.
    assign haz = ex_valid & ex_mem_read & (ex_rt != 5'd0) & id_valid &
                 ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    assign stall = haz & ~flush & ~reset;

    always_ff @(posedge clk) begin
        if (reset)
            bubble_cnt <= '0;
        else if (haz && !flush && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);

        if (reset || flush || haz) begin
            ex_valid      <= 1'b0;
            ex_alu_op     <= '0;
            ex_funct      <= '0;
            ex_opcode     <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_branch     <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_reg_dst    <= 1'b0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rd         <= '0;
            ex_rd1        <= '0;
            ex_rd2        <= '0;
            ex_imm        <= '0;
            ex_pc4        <= '0;
        end else begin
            ex_valid      <= id_valid;
            ex_alu_op     <= id_alu_op;
            ex_funct      <= id_funct;
            ex_opcode     <= id_opcode;
            // An empty ID slot must not write registers or memory downstream.
            ex_reg_write  <= id_valid & id_reg_write;
            ex_mem_read   <= id_valid & id_mem_read;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_mem_to_reg <= id_valid & id_mem_to_reg;
            ex_branch     <= id_valid & id_branch;
            ex_alu_src    <= id_valid & id_alu_src;
            ex_reg_dst    <= id_valid & id_reg_dst;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rd         <= id_rd;
            ex_rd1        <= id_rd1;
            ex_rd2        <= id_rd2;
            ex_imm        <= id_imm;
            ex_pc4        <= id_pc4;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, corner sequences and
// randomized traffic against an abstract pipeline-register model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        flush;
        logic        valid;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic [5:0]  opcode;
        logic [6:0]  ctrl;      // {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, reg_dst}
        logic        uses_rt;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, rd2, imm, pc4;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [1:0]  alu_op;
        logic [5:0]  funct;
        logic [5:0]  opcode;
        logic [6:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, rd2, imm, pc4;
    } ex_t;

    typedef struct {
        in_t         in;
        logic        exp_stall;
        logic        exp_valid;
        logic [6:0]  exp_ctrl;
        logic [4:0]  exp_rt;
        int unsigned exp_cnt;
    } vec_t;

    localparam logic [6:0] C_RTYPE = 7'b1000001;
    localparam logic [6:0] C_LW    = 7'b1101010;
    localparam logic [6:0] C_ADDI  = 7'b1000010;
    localparam logic [6:0] C_SW    = 7'b0010010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, flush, id_valid, id_uses_rt;
    logic [1:0] id_alu_op;
    logic [5:0] id_funct, id_opcode;
    logic [6:0] id_ctrl;
    logic [4:0] id_rs, id_rt, id_rd;
    logic [31:0] id_rd1, id_rd2, id_imm, id_pc4;

    logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src, ex_reg_dst;
    logic [1:0] ex_alu_op;
    logic [5:0] ex_funct, ex_opcode;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rd1, ex_rd2, ex_imm, ex_pc4;
    logic stall;
    logic [15:0] bubble_cnt;

    logic s_valid, s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg, s_branch, s_alu_src, s_reg_dst;
    logic [1:0] s_alu_op;
    logic [5:0] s_funct, s_opcode;
    logic [4:0] s_rs, s_rt, s_rd;
    logic [31:0] s_rd1, s_rd2, s_imm, s_pc4;
    logic s_stall;
    logic [1:0] s_cnt;

    id_ex_stage #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_opcode(id_opcode),
        .id_reg_write(id_ctrl[6]), .id_mem_read(id_ctrl[5]), .id_mem_write(id_ctrl[4]),
        .id_mem_to_reg(id_ctrl[3]), .id_branch(id_ctrl[2]), .id_alu_src(id_ctrl[1]),
        .id_reg_dst(id_ctrl[0]), .id_uses_rt(id_uses_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct), .ex_opcode(ex_opcode),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_alu_src(ex_alu_src),
        .ex_reg_dst(ex_reg_dst), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .stall(stall), .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
        .id_alu_op(id_alu_op), .id_funct(id_funct), .id_opcode(id_opcode),
        .id_reg_write(id_ctrl[6]), .id_mem_read(id_ctrl[5]), .id_mem_write(id_ctrl[4]),
        .id_mem_to_reg(id_ctrl[3]), .id_branch(id_ctrl[2]), .id_alu_src(id_ctrl[1]),
        .id_reg_dst(id_ctrl[0]), .id_uses_rt(id_uses_rt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc4(id_pc4),
        .ex_valid(s_valid), .ex_alu_op(s_alu_op), .ex_funct(s_funct), .ex_opcode(s_opcode),
        .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
        .ex_mem_to_reg(s_mem_to_reg), .ex_branch(s_branch), .ex_alu_src(s_alu_src),
        .ex_reg_dst(s_reg_dst), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
        .ex_rd1(s_rd1), .ex_rd2(s_rd2), .ex_imm(s_imm), .ex_pc4(s_pc4),
        .stall(s_stall), .bubble_cnt(s_cnt)
    );

    int checks = 0;
    int failures = 0;
    ex_t m;                 // model of what EX holds
    int unsigned nbub;      // unbounded bubble count since last reset
    logic last_stall;

    function automatic ex_t dut_ex();
        return {ex_valid, ex_alu_op, ex_funct, ex_opcode,
                {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src, ex_reg_dst},
                ex_rs, ex_rt, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc4};
    endfunction

    function automatic ex_t sat_ex();
        return {s_valid, s_alu_op, s_funct, s_opcode,
                {s_reg_write, s_mem_read, s_mem_write, s_mem_to_reg, s_branch, s_alu_src, s_reg_dst},
                s_rs, s_rt, s_rd, s_rd1, s_rd2, s_imm, s_pc4};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic in_t mk(input logic valid, input logic [1:0] alu_op, input logic [5:0] funct,
                               input logic [5:0] opcode, input logic [6:0] ctrl, input logic uses_rt,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic fl);
        in_t v;
        v.flush = fl; v.valid = valid; v.alu_op = alu_op; v.funct = funct; v.opcode = opcode;
        v.ctrl = ctrl; v.uses_rt = uses_rt; v.rs = rs; v.rt = rt; v.rd = rd;
        v.rd1 = $urandom; v.rd2 = $urandom; v.imm = $urandom; v.pc4 = $urandom;
        return v;
    endfunction

    function automatic int unsigned sat(input int unsigned n, input int unsigned lim);
        return (n > lim) ? lim : n;
    endfunction

    // Drive one cycle of ID inputs, check stall before the edge and the whole EX state after it.
    task automatic apply(input in_t v, input logic rst);
        logic haz;
        ex_t nxt;
        reset = rst; flush = v.flush; id_valid = v.valid; id_alu_op = v.alu_op;
        id_funct = v.funct; id_opcode = v.opcode; id_ctrl = v.ctrl; id_uses_rt = v.uses_rt;
        id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
        id_rd1 = v.rd1; id_rd2 = v.rd2; id_imm = v.imm; id_pc4 = v.pc4;
        #1;
        haz = m.valid && m.ctrl[5] && m.rt != 0 && v.valid &&
              (m.rt == v.rs || (v.uses_rt && m.rt == v.rt));
        last_stall = stall;
        chk("stall", stall, haz && !v.flush && !rst);
        chk("stall_sat", s_stall, haz && !v.flush && !rst);
        if (rst) begin
            nxt = '0; nbub = 0;
        end else if (v.flush) begin
            nxt = '0;
        end else if (haz) begin
            nxt = '0; nbub++;
        end else begin
            nxt = {v.valid, v.alu_op, v.funct, v.opcode, v.valid ? v.ctrl : 7'b0,
                   v.rs, v.rt, v.rd, v.rd1, v.rd2, v.imm, v.pc4};
        end
        @(posedge clk);
        #1;
        m = nxt;
        chk("ex_state", dut_ex(), m);
        chk("ex_state_sat", sat_ex(), m);
        chk("bubble_cnt", bubble_cnt, sat(nbub, 16'hffff));
        chk("bubble_cnt_sat", s_cnt, sat(nbub, 3));
    endtask

    vec_t vecs[14];

    initial begin
        in_t v;
        m = '0; nbub = 0;

        // Reset with busy, nonzero inputs
        v = mk(1, 2'b10, 6'h22, 6'h3f, 7'h7f, 1, 5'd7, 5'd8, 5'd9, 0);
        apply(v, 1);
        apply(v, 1);
        chk("reset_zero", dut_ex(), 0);
        chk("reset_cnt", bubble_cnt, 0);

        vecs[0]  = '{mk(1, 2'b10, 6'b100010, 6'h00, C_RTYPE, 1, 5'd1, 5'd2, 5'd9, 0),  0, 1, C_RTYPE, 5'd2, 0};
        vecs[0].in.rd1 = 32'h5; vecs[0].in.rd2 = 32'h3;
        vecs[1]  = '{mk(1, 2'b00, 6'h00, 6'h23, C_LW,    0, 5'd4, 5'd8, 5'd0, 0),  0, 1, C_LW,    5'd8, 0};
        vecs[2]  = '{mk(1, 2'b10, 6'h20, 6'h00, C_RTYPE, 1, 5'd8, 5'd3, 5'd10, 0), 1, 0, 7'b0,    5'd0, 1};
        vecs[3]  = vecs[2]; vecs[3].exp_stall = 0; vecs[3].exp_valid = 1;
        vecs[3].exp_ctrl = C_RTYPE; vecs[3].exp_rt = 5'd3;
        vecs[4]  = vecs[1]; vecs[4].exp_cnt = 1;
        vecs[5]  = '{mk(1, 2'b00, 6'h00, 6'h08, C_ADDI,  0, 5'd4, 5'd8, 5'd0, 0),  0, 1, C_ADDI,  5'd8, 1};
        vecs[6]  = vecs[4];
        vecs[7]  = '{mk(1, 2'b00, 6'h00, 6'h2b, C_SW,    1, 5'd4, 5'd8, 5'd0, 0),  1, 0, 7'b0,    5'd0, 2};
        vecs[8]  = vecs[7]; vecs[8].exp_stall = 0; vecs[8].exp_valid = 1;
        vecs[8].exp_ctrl = C_SW; vecs[8].exp_rt = 5'd8;
        vecs[9]  = vecs[1]; vecs[9].exp_cnt = 2;
        vecs[10] = '{mk(1, 2'b10, 6'h20, 6'h00, C_RTYPE, 1, 5'd8, 5'd3, 5'd10, 1), 0, 0, 7'b0,    5'd0, 2};
        vecs[11] = '{mk(1, 2'b00, 6'h00, 6'h23, C_LW,    0, 5'd4, 5'd0, 5'd0, 0),  0, 1, C_LW,    5'd0, 2};
        vecs[12] = '{mk(1, 2'b10, 6'h20, 6'h00, C_RTYPE, 1, 5'd0, 5'd0, 5'd11, 0), 0, 1, C_RTYPE, 5'd0, 2};
        vecs[13] = '{mk(0, 2'b10, 6'h20, 6'h00, 7'h7f,   1, 5'd1, 5'd5, 5'd12, 0), 0, 0, 7'b0,    5'd5, 2};

        for (int i = 0; i < 14; i++) begin
            apply(vecs[i].in, 0);
            chk($sformatf("vec%0d_stall", i), last_stall, vecs[i].exp_stall);
            chk($sformatf("vec%0d_valid", i), ex_valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_ctrl", i),
                {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_alu_src, ex_reg_dst},
                vecs[i].exp_ctrl);
            chk($sformatf("vec%0d_rt", i), ex_rt, vecs[i].exp_rt);
            chk($sformatf("vec%0d_cnt", i), bubble_cnt, vecs[i].exp_cnt);
            if (i == 0) begin
                chk("pass_rd1", ex_rd1, 32'h5);
                chk("pass_rd2", ex_rd2, 32'h3);
                chk("pass_rd", ex_rd, 5'd9);
                chk("pass_funct", ex_funct, 6'b100010);
                chk("pass_alu_op", ex_alu_op, 2'b10);
            end
        end

        // Reset asserted while a load-use hazard is pending
        apply(vecs[1].in, 0);
        apply(vecs[2].in, 1);
        chk("rst_mid_haz_stall", last_stall, 0);
        chk("rst_mid_haz_state", dut_ex(), 0);
        chk("rst_mid_haz_cnt", bubble_cnt, 0);

        // Five hazards: narrow counter must hold at 3
        for (int k = 1; k <= 5; k++) begin
            apply(vecs[1].in, 0);
            apply(vecs[2].in, 0);
            chk("sat_stall", last_stall, 1);
            chk("sat_cnt16", bubble_cnt, k);
            chk("sat_cnt2", s_cnt, (k > 3) ? 3 : k);
        end

        // Randomized traffic biased toward register collisions and loads
        for (int n = 0; n < 600; n++) begin
            v = mk($urandom_range(0, 9) != 0, 2'($urandom), 6'($urandom), 6'($urandom),
                   7'($urandom), 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom), $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) != 0) v.ctrl[5] = 1'b1;
            apply(v, $urandom_range(0, 39) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
